// File: rtl/par_join_pkg.sv
// par_join_pkg: shared types and constants for the parallel-join collector.
//   join_mode_e  - join semantics requested with a fork (RSVD behaves as JOIN)
//   join_state_e - collector FSM states
//   TIMEOUT_CYC_DEF - default WAIT/DRAIN cycle limit for the optional watchdog
package par_join_pkg;

  typedef enum logic [1:0] {
    JOIN      = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2,
    RSVD      = 2'd3
  } join_mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } join_state_e;

  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/join_pending_mask.sv
// join_pending_mask: outstanding-branch mask for the parallel-join collector.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   set_all_i    - load all ones (fork launched)
//   clr_en_i     - honour done pulses this cycle
//   force_clr_i  - clear the whole mask (watchdog)
//   done_i       - per-branch completion pulses
//   pending_o    - registered outstanding mask
//   any_valid_o  - at least one done pulse hits a pending branch
//   empty_o      - mask is empty once this cycle's valid completions apply
//   lo_idx_o     - lowest index among valid completions
//   hi_idx_o     - highest index among valid completions
module join_pending_mask #(
  parameter int NUM_BRANCH = 4,
  localparam int IDX_W     = $clog2(NUM_BRANCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_all_i,
  input  logic                  clr_en_i,
  input  logic                  force_clr_i,
  input  logic [NUM_BRANCH-1:0] done_i,
  output logic [NUM_BRANCH-1:0] pending_o,
  output logic                  any_valid_o,
  output logic                  empty_o,
  output logic [IDX_W-1:0]      lo_idx_o,
  output logic [IDX_W-1:0]      hi_idx_o
);

  logic [NUM_BRANCH-1:0] pending_q, pending_d, valid_done;

  // Done pulses for branches that are not outstanding are dropped here.
  assign valid_done  = clr_en_i ? (done_i & pending_q) : '0;
  assign any_valid_o = |valid_done;
  assign empty_o     = ~|(pending_q & ~valid_done);
  assign pending_o   = pending_q;

  // NOTE: every variable in a combinational block gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending_q & ~valid_done;
    if (force_clr_i)    pending_d = '0;
    else if (set_all_i) pending_d = '1;
  end

  // Priority encoders: the last match in each loop wins.
  always_comb begin
    lo_idx_o = '0;
    hi_idx_o = '0;
    for (int i = NUM_BRANCH - 1; i >= 0; i--)
      if (valid_done[i]) lo_idx_o = IDX_W'(i);
    for (int i = 0; i < NUM_BRANCH; i++)
      if (valid_done[i]) hi_idx_o = IDX_W'(i);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/par_join_collector.sv
// par_join_collector: launches NUM_BRANCH parallel branches and releases the
// parent with JOIN / JOIN_ANY / JOIN_NONE semantics.
// Optional build macro: PAR_JOIN_TIMEOUT_EN adds a WAIT/DRAIN watchdog and
// the `timeout` output.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start, mode  - fork request and join mode (sampled in IDLE)
//   data_in      - parent operand, the JOIN_NONE result
//   branch_go    - one-cycle launch pulse to all branches
//   branch_done  - per-branch completion pulses
//   branch_data  - per-branch results, slice i valid with branch_done[i]
//   join_done    - one-cycle parent release
//   result       - registered join result, held until the next join_done
//   busy         - fork in flight (state != IDLE)
//   pending      - outstanding-branch mask
//   err_busy     - start seen while busy (ignored)
//   timeout      - watchdog fired (PAR_JOIN_TIMEOUT_EN only)
module par_join_collector
  import par_join_pkg::*;
#(
  parameter int NUM_BRANCH  = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [DATA_W-1:0]            data_in,
  output logic [NUM_BRANCH-1:0]        branch_go,
  input  logic [NUM_BRANCH-1:0]        branch_done,
  input  logic [NUM_BRANCH*DATA_W-1:0] branch_data,
  output logic                         join_done,
  output logic [DATA_W-1:0]            result,
  output logic                         busy,
  output logic [NUM_BRANCH-1:0]        pending,
  output logic                         err_busy
`ifdef PAR_JOIN_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam int IDX_W = $clog2(NUM_BRANCH);

  join_state_e       state_q, state_d;
  join_mode_e        mode_q, mode_d;
  logic              join_done_q, join_done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              set_all, clr_en, force_clr;
  logic              any_valid, empty;
  logic [IDX_W-1:0]  lo_idx, hi_idx;

  join_pending_mask #(.NUM_BRANCH(NUM_BRANCH)) u_mask (
    .clk         (clk),
    .rst         (rst),
    .set_all_i   (set_all),
    .clr_en_i    (clr_en),
    .force_clr_i (force_clr),
    .done_i      (branch_done),
    .pending_o   (pending),
    .any_valid_o (any_valid),
    .empty_o     (empty),
    .lo_idx_o    (lo_idx),
    .hi_idx_o    (hi_idx)
  );

  assign branch_go = {NUM_BRANCH{state_q == S_LAUNCH}};
  assign busy      = (state_q != S_IDLE);
  assign err_busy  = start && (state_q != S_IDLE);
  assign join_done = join_done_q;
  assign result    = result_q;

`ifdef PAR_JOIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             in_wait_drain;
  assign in_wait_drain = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign timeout       = timeout_q;
  assign cnt_d         = in_wait_drain ? cnt_q + CNT_W'(1) : '0;
`else
  // No watchdog in this build; TIMEOUT_CYC is kept so both builds share one
  // parameter list.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    join_done_d = 1'b0;
    result_d    = result_q;
    set_all     = 1'b0;
    clr_en      = 1'b0;
    force_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LAUNCH;
          mode_d  = join_mode_e'(mode);
          set_all = 1'b1;
          // JOIN_NONE releases the parent in the launch cycle itself.
          if (join_mode_e'(mode) == JOIN_NONE) begin
            join_done_d = 1'b1;
            result_d    = data_in;
          end
        end
      end
      // Done pulses are not honoured here: branches have not seen branch_go.
      S_LAUNCH: state_d = (mode_q == JOIN_NONE) ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        clr_en = 1'b1;
        if (mode_q == JOIN_ANY) begin
          if (any_valid) begin
            join_done_d = 1'b1;
            result_d    = branch_data[int'(lo_idx)*DATA_W +: DATA_W];
            state_d     = empty ? S_IDLE : S_DRAIN;
          end
        end else if (any_valid && empty) begin
          join_done_d = 1'b1;
          result_d    = branch_data[int'(hi_idx)*DATA_W +: DATA_W];
          state_d     = S_IDLE;
        end
      end
      S_DRAIN: begin
        clr_en = 1'b1;
        if (empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PAR_JOIN_TIMEOUT_EN
    timeout_d = 1'b0;
    // Watchdog overrides anything short of a normal return to IDLE.
    if (in_wait_drain && cnt_q == CNT_LAST && state_d != S_IDLE) begin
      force_clr = 1'b1;
      timeout_d = 1'b1;
      if (state_q == S_WAIT) join_done_d = 1'b1;
      result_d  = result_q;
      state_d   = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= JOIN;
      join_done_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      join_done_q <= join_done_d;
      result_q    <= result_d;
    end
  end

`ifdef PAR_JOIN_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_par_join_collector.sv
// tb_par_join_collector: directed self-checking bench for par_join_collector
// (NUM_BRANCH=4, DATA_W=8). Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_par_join_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  data_in = 8'h00;
  logic [3:0]  branch_go;
  logic [3:0]  branch_done = 4'h0;
  logic [31:0] branch_data = 32'h0;
  logic        join_done;
  logic [7:0]  result;
  logic        busy;
  logic [3:0]  pending;
  logic        err_busy;
`ifdef PAR_JOIN_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  par_join_collector #(.NUM_BRANCH(4), .DATA_W(8), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .data_in     (data_in),
    .branch_go   (branch_go),
    .branch_done (branch_done),
    .branch_data (branch_data),
    .join_done   (join_done),
    .result      (result),
    .busy        (busy),
    .pending     (pending),
    .err_busy    (err_busy)
`ifdef PAR_JOIN_TIMEOUT_EN
    ,
    .timeout     (timeout)
`endif
  );

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    sample();
    checks++; if (branch_go !== 4'h0) begin errors++; $display("FAIL rst_go got=%h exp=0", branch_go); end
    checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL rst_join got=%b exp=0", join_done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rst_result got=%h exp=00", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rst_pending got=%b exp=0000", pending); end
    checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err_busy); end
    next_cycle();
    rst = 1'b0;
  endtask

  // JOIN, completions 2,0,3,1; a done pulse during LAUNCH must be ignored.
  task automatic test_join();
    next_cycle(); start = 1'b1; mode = 2'd0; data_in = 8'h10;
    next_cycle(); start = 1'b0; branch_done = 4'b0001; branch_data = 32'h0000_0099;
    sample();
    checks++; if (branch_go !== 4'hF) begin errors++; $display("FAIL join_go got=%b exp=1111", branch_go); end
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL join_launch_pend got=%b exp=1111", pending); end
    next_cycle(); branch_done = 4'b0100; branch_data = 32'h0021_0000;
    sample();
    checks++; if (pending !== 4'hF) begin errors++; $display("FAIL join_launch_done_ignored got=%b exp=1111", pending); end
    checks++; if (branch_go !== 4'h0) begin errors++; $display("FAIL join_go_once got=%b exp=0000", branch_go); end
    next_cycle(); branch_done = 4'b0001; branch_data = 32'h0000_0022;
    sample();
    checks++; if (pending !== 4'b1011) begin errors++; $display("FAIL join_pend_a got=%b exp=1011", pending); end
    next_cycle(); branch_done = 4'b1000; branch_data = 32'h2300_0000;
    next_cycle(); branch_done = 4'b0010; branch_data = 32'h0000_2400;
    sample();
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL join_pend_b got=%b exp=0010", pending); end
    checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL join_early got=%b exp=0", join_done); end
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL join_done got=%b exp=1", join_done); end
    checks++; if (result !== 8'h24) begin errors++; $display("FAIL join_result got=%h exp=24", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL join_busy got=%b exp=0", busy); end
    next_cycle();
    sample();
    checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL join_single got=%b exp=0", join_done); end
    checks++; if (result !== 8'h24) begin errors++; $display("FAIL join_hold got=%h exp=24", result); end
  endtask

  // JOIN, branches 1 and 3 finish together last: highest index wins.
  task automatic test_join_highest();
    next_cycle(); start = 1'b1; mode = 2'd0; data_in = 8'h00;
    next_cycle(); start = 1'b0;
    next_cycle(); branch_done = 4'b0101; branch_data = 32'h0011_0012;
    next_cycle(); branch_done = 4'b1010; branch_data = 32'h6600_5500;
    sample();
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL hi_pend got=%b exp=1010", pending); end
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL hi_done got=%b exp=1", join_done); end
    checks++; if (result !== 8'h66) begin errors++; $display("FAIL hi_result got=%h exp=66", result); end
  endtask

  // JOIN_ANY: lowest index wins, drain keeps busy, start while draining errs.
  task automatic test_join_any();
    next_cycle(); start = 1'b1; mode = 2'd1;
    next_cycle(); start = 1'b0;
    next_cycle(); branch_done = 4'b0101; branch_data = 32'h0044_0033;
    next_cycle(); branch_done = 4'b0000; start = 1'b1;
    sample();
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL any_done got=%b exp=1", join_done); end
    checks++; if (result !== 8'h33) begin errors++; $display("FAIL any_result got=%h exp=33", result); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL any_busy got=%b exp=1", busy); end
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL any_pend got=%b exp=1010", pending); end
    checks++; if (err_busy !== 1'b1) begin errors++; $display("FAIL any_err got=%b exp=1", err_busy); end
    next_cycle(); start = 1'b0; branch_done = 4'b0010; branch_data = 32'h0000_7700;
    sample();
    checks++; if (branch_go !== 4'h0) begin errors++; $display("FAIL any_no_go got=%b exp=0000", branch_go); end
    checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL any_single got=%b exp=0", join_done); end
    checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL any_err_pulse got=%b exp=0", err_busy); end
    next_cycle(); branch_done = 4'b1000; branch_data = 32'h8800_0000;
    sample();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL any_drain_busy got=%b exp=1", busy); end
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL any_drain_pend got=%b exp=1000", pending); end
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL any_idle got=%b exp=0", busy); end
    checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL any_drain_join got=%b exp=0", join_done); end
    checks++; if (result !== 8'h33) begin errors++; $display("FAIL any_drain_result got=%h exp=33", result); end
  endtask

  // JOIN_NONE: release in the launch cycle, busy until all four drain.
  task automatic test_join_none();
    next_cycle(); start = 1'b1; mode = 2'd2; data_in = 8'hAB;
    next_cycle(); start = 1'b0; data_in = 8'h00;
    sample();
    checks++; if (branch_go !== 4'hF) begin errors++; $display("FAIL none_go got=%b exp=1111", branch_go); end
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL none_done got=%b exp=1", join_done); end
    checks++; if (result !== 8'hAB) begin errors++; $display("FAIL none_result got=%h exp=AB", result); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); branch_done = 4'(1 << i); branch_data = 32'hEEEE_EEEE;
      sample();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL none_busy_%0d got=%b exp=1", i, busy); end
      checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL none_extra_%0d got=%b exp=0", i, join_done); end
    end
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL none_idle got=%b exp=0", busy); end
    checks++; if (result !== 8'hAB) begin errors++; $display("FAIL none_hold got=%h exp=AB", result); end
  endtask

  // Reset in WAIT with pending=0101, then a late done pulse.
  task automatic test_reset_mid();
    next_cycle(); start = 1'b1; mode = 2'd0;
    next_cycle(); start = 1'b0;
    next_cycle(); branch_done = 4'b1010; branch_data = 32'h0101_0101;
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (pending !== 4'b0101) begin errors++; $display("FAIL rmid_pend got=%b exp=0101", pending); end
    next_cycle(); rst = 1'b1;
    sample();
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rmid_pend_clr got=%b exp=0000", pending); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rmid_result got=%h exp=00", result); end
    next_cycle(); rst = 1'b0; branch_done = 4'b0100; branch_data = 32'h0077_0000;
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (join_done !== 1'b0) begin errors++; $display("FAIL rmid_late got=%b exp=0", join_done); end
    checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rmid_late_pend got=%b exp=0000", pending); end
  endtask

  // Reserved mode acts as JOIN; next fork starts 3 cycles after the first.
  task automatic test_back_to_back();
    next_cycle(); start = 1'b1; mode = 2'd3;
    next_cycle(); start = 1'b0;
    next_cycle(); branch_done = 4'hF; branch_data = 32'h0403_0201;
    next_cycle(); branch_done = 4'h0; start = 1'b1; mode = 2'd1;
    sample();
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", join_done); end
    checks++; if (result !== 8'h04) begin errors++; $display("FAIL b2b_result1 got=%h exp=04", result); end
    checks++; if (err_busy !== 1'b0) begin errors++; $display("FAIL b2b_err got=%b exp=0", err_busy); end
    next_cycle(); start = 1'b0;
    sample();
    checks++; if (branch_go !== 4'hF) begin errors++; $display("FAIL b2b_go got=%b exp=1111", branch_go); end
    next_cycle(); branch_done = 4'hF;
    next_cycle(); branch_done = 4'h0;
    sample();
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", join_done); end
    checks++; if (result !== 8'h01) begin errors++; $display("FAIL b2b_result2 got=%h exp=01", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b exp=0", busy); end
  endtask

`ifdef PAR_JOIN_TIMEOUT_EN
  // Branch 2 never completes: watchdog fires after 8 WAIT cycles.
  task automatic test_timeout();
    next_cycle(); start = 1'b1; mode = 2'd0;
    next_cycle(); start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      next_cycle(); branch_done = (i == 1) ? 4'b1011 : 4'b0000; branch_data = 32'h5555_5555;
      sample();
      checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early_%0d timeout=%b busy=%b exp=0/1", i, timeout, busy); end
    end
    next_cycle(); branch_done = 4'b0000;
    sample();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", timeout); end
    checks++; if (join_done !== 1'b1) begin errors++; $display("FAIL to_join got=%b exp=1", join_done); end
    checks++; if (result !== 8'h01) begin errors++; $display("FAIL to_result got=%h exp=01", result); end
    checks++; if (busy !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL to_idle busy=%b pending=%b exp=0/0000", busy, pending); end
  endtask
`endif

  initial begin
    test_reset();
    test_join();
    test_join_highest();
    test_join_any();
    test_join_none();
    test_reset_mid();
    test_back_to_back();
`ifdef PAR_JOIN_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
